// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues req/ack fetches and presents {instr, pcplus1, epc} to IF/ID.
// Latency: one cycle from request to updated outputs with a zero-wait memory, plus one per wait/steal cycle.
// Backpressure: stall_pc_i holds PC and outputs, mem_busy_i suppresses the request, stall_req_o is raised until the fetch lands.
//
// Ports: CLK/RST (async, active-low); stall_pc_i, branch_i/branch_target_i, int_i, eret_i/epc_ret_i
//        (redirect control); mem_busy_i (bus lent to MEM); imem_req_o/imem_addr_o/imem_ack_i/imem_data_i
//        (fetch port); instr_o/pcplus1_o/epc_o (IF/ID payload); stall_req_o (fetch incomplete).
// Build option IF_PERF_CNT_EN adds fetch_stall_cnt_o, a saturating count of stall_req_o cycles.
module if_fetch #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] INT_VECTOR = 16'h0008,
   parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall_pc_i,
   input  logic        branch_i,
   input  logic [15:0] branch_target_i,
   input  logic        int_i,
   input  logic        eret_i,
   input  logic [15:0] epc_ret_i,
   input  logic        mem_busy_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [15:0] imem_data_i,
   output logic [15:0] instr_o,
   output logic [15:0] pcplus1_o,
   output logic [15:0] epc_o,
`ifdef IF_PERF_CNT_EN
   output logic [15:0] fetch_stall_cnt_o,
`endif
   output logic        stall_req_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] pc;
   logic        req_sent;     // a request went out earlier in this fetch and is still unanswered
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] next_pc;
   logic        fetch_req;
   logic        accept;

   always_comb begin
      redirect    = int_i | eret_i | branch_i;
      redirect_pc = branch_target_i;
      if (int_i)
         redirect_pc = INT_VECTOR;
      else if (eret_i)
         redirect_pc = epc_ret_i;
      next_pc = redirect ? redirect_pc : pc + 16'd1;
   end

   // Reset is folded in so the request and stall are quiet while RST is asserted.
   assign fetch_req   = RST && (state == S_FETCH) && !mem_busy_i;
   assign accept      = fetch_req && imem_ack_i;
   assign imem_req_o  = fetch_req;
   assign imem_addr_o = pc;
   assign stall_req_o = RST && ((state == S_DRAIN) || ((state == S_FETCH) && !accept));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         req_sent  <= 1'b0;
         instr_o   <= NOP_INSTR;
         pcplus1_o <= RESET_PC + 16'd1;
         epc_o     <= RESET_PC;
      end else begin
         case (state)
            S_FETCH: begin
               if (accept) begin
                  // Word is captured even when a redirect arrives on the same edge.
                  instr_o   <= imem_data_i;
                  epc_o     <= pc;
                  pcplus1_o <= pc + 16'd1;
                  req_sent  <= 1'b0;
                  if (redirect || !stall_pc_i)
                     pc <= next_pc;
                  else
                     state <= S_HOLD;
               end else if (redirect) begin
                  pc       <= next_pc;
                  req_sent <= 1'b0;
                  // Only drain if memory actually saw a request; otherwise no ack will ever come.
                  if (fetch_req || req_sent)
                     state <= S_DRAIN;
               end else if (fetch_req) begin
                  req_sent <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect || !stall_pc_i) begin
                  pc    <= next_pc;
                  state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               // The stale word is dropped; only the handshake matters here.
               if (redirect)
                  pc <= next_pc;
               if (imem_ack_i)
                  state <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         fetch_stall_cnt_o <= 16'h0000;
      else if (stall_req_o && (fetch_stall_cnt_o != 16'hFFFF))
         fetch_stall_cnt_o <= fetch_stall_cnt_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level reference tracks PC and the outstanding-fetch situation and is compared every cycle.
// The memory model acks after a programmable delay and returns addr ^ 16'hA5A5.
module tb_if_fetch;

   logic        CLK;
   logic        RST;
   logic        stall_pc_i;
   logic        branch_i;
   logic [15:0] branch_target_i;
   logic        int_i;
   logic        eret_i;
   logic [15:0] epc_ret_i;
   logic        mem_busy_i;
   logic        imem_req_o;
   logic [15:0] imem_addr_o;
   logic        imem_ack_i;
   logic [15:0] imem_data_i;
   logic [15:0] instr_o;
   logic [15:0] pcplus1_o;
   logic [15:0] epc_o;
   logic        stall_req_o;
`ifdef IF_PERF_CNT_EN
   logic [15:0] fetch_stall_cnt_o;
`endif

   if_fetch dut (
      .CLK             (CLK),
      .RST             (RST),
      .stall_pc_i      (stall_pc_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .int_i           (int_i),
      .eret_i          (eret_i),
      .epc_ret_i       (epc_ret_i),
      .mem_busy_i      (mem_busy_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ack_i      (imem_ack_i),
      .imem_data_i     (imem_data_i),
      .instr_o         (instr_o),
      .pcplus1_o       (pcplus1_o),
      .epc_o           (epc_o),
`ifdef IF_PERF_CNT_EN
      .fetch_stall_cnt_o(fetch_stall_cnt_o),
`endif
      .stall_req_o     (stall_req_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- memory model ----------------
   logic        mem_out;
   logic [15:0] mem_addr;
   int          mem_cnt;
   int          cur_delay;

   assign imem_ack_i  = mem_out ? (mem_cnt == 0) : (imem_req_o && (cur_delay == 0));
   assign imem_data_i = (mem_out ? mem_addr : imem_addr_o) ^ 16'hA5A5;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mem_out  <= 1'b0;
         mem_addr <= 16'h0000;
         mem_cnt  <= 0;
      end else if (imem_ack_i) begin
         mem_out <= 1'b0;
      end else if (mem_out) begin
         mem_cnt <= mem_cnt - 1;
      end else if (imem_req_o) begin
         mem_out  <= 1'b1;
         mem_addr <= imem_addr_o;
         mem_cnt  <= cur_delay - 1;
      end
   end

   // ---------------- reference model ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_pc;
   logic        m_hold, m_drain, m_sent;
   logic [15:0] m_instr, m_epc, m_pcp1;
   int          m_cnt;
   logic        s_req, s_stall;
   logic [15:0] s_addr;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_cycle();
      logic        redir, exp_req, acc, exp_stall;
      logic [15:0] tgt;
      redir = int_i | eret_i | branch_i;
      tgt   = int_i ? 16'h0008 : (eret_i ? epc_ret_i : branch_target_i);
      exp_req   = !m_hold && !m_drain && !mem_busy_i;
      acc       = exp_req && imem_ack_i;
      exp_stall = m_drain || (!m_hold && !acc);

      chk("imem_req", {15'd0, imem_req_o}, {15'd0, exp_req});
      chk("stall_req", {15'd0, stall_req_o}, {15'd0, exp_stall});
      if (exp_req) chk("imem_addr", imem_addr_o, m_pc);
      chk("instr", instr_o, m_instr);
      chk("epc", epc_o, m_epc);
      chk("pcplus1", pcplus1_o, m_pcp1);
`ifdef IF_PERF_CNT_EN
      chk("stall_cnt", fetch_stall_cnt_o, 16'(m_cnt));
      if (exp_stall && m_cnt < 65535) m_cnt++;
`endif
      s_req = imem_req_o; s_stall = stall_req_o; s_addr = imem_addr_o;

      if (m_drain) begin
         if (redir) m_pc = tgt;
         if (imem_ack_i) m_drain = 1'b0;
      end else if (m_hold) begin
         if (redir) begin m_pc = tgt; m_hold = 1'b0; end
         else if (!stall_pc_i) begin m_pc = m_pc + 16'd1; m_hold = 1'b0; end
      end else if (acc) begin
         m_instr = m_pc ^ 16'hA5A5;
         m_epc   = m_pc;
         m_pcp1  = m_pc + 16'd1;
         m_sent  = 1'b0;
         if (redir) m_pc = tgt;
         else if (stall_pc_i) m_hold = 1'b1;
         else m_pc = m_pc + 16'd1;
      end else if (redir) begin
         if (exp_req || m_sent) m_drain = 1'b1;
         m_sent = 1'b0;
         m_pc   = tgt;
      end else if (exp_req) begin
         m_sent = 1'b1;
      end
   endtask

   task automatic step(input logic st, input logic br, input logic [15:0] tgt, input logic it,
                       input logic er, input logic [15:0] eaddr, input logic busy, input int dly);
      stall_pc_i      = st;
      branch_i        = br;
      branch_target_i = tgt;
      int_i           = it;
      eret_i          = er;
      epc_ret_i       = eaddr;
      mem_busy_i      = busy && !mem_out;   // the bus is only lent while no fetch is in flight
      cur_delay       = dly;
      @(negedge CLK);
      model_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int dly);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, dly);
   endtask

   initial begin
      int cnt_before;
      cnt_before = 0;
      RST = 1'b1;
      stall_pc_i = 0; branch_i = 0; branch_target_i = 0; int_i = 0; eret_i = 0;
      epc_ret_i = 0; mem_busy_i = 0; cur_delay = 0;
      #2 RST = 1'b0;
      #10;
      chk("rst_req", {15'd0, imem_req_o}, 16'd0);
      chk("rst_stall", {15'd0, stall_req_o}, 16'd0);
      chk("rst_instr", instr_o, 16'h0800);
      chk("rst_pcplus1", pcplus1_o, 16'h0001);
      chk("rst_epc", epc_o, 16'h0000);
      chk("rst_addr", imem_addr_o, 16'h0000);
`ifdef IF_PERF_CNT_EN
      chk("rst_cnt", fetch_stall_cnt_o, 16'h0000);
`endif
      m_pc = 16'h0000; m_hold = 0; m_drain = 0; m_sent = 0;
      m_instr = 16'h0800; m_epc = 16'h0000; m_pcp1 = 16'h0001; m_cnt = 0;
      @(posedge CLK); #1;
      RST = 1'b1;

      // 1: zero-wait streaming
      idle(0);
      chk("t1_addr0", s_addr, 16'h0000);
      chk("t1_epc", epc_o, 16'h0000);
      chk("t1_pcplus1", pcplus1_o, 16'h0001);
      chk("t1_instr", instr_o, 16'hA5A5);
      idle(0); chk("t1_addr1", s_addr, 16'h0001);
      idle(0); chk("t1_addr2", s_addr, 16'h0002);
      idle(0);

      // 2: three wait states at pc=4
      idle(3); chk("t2_stall_a", {15'd0, s_stall}, 16'd1); chk("t2_addr_a", s_addr, 16'h0004);
      idle(0); chk("t2_stall_b", {15'd0, s_stall}, 16'd1); chk("t2_addr_b", s_addr, 16'h0004);
      idle(0); chk("t2_stall_c", {15'd0, s_stall}, 16'd1);
      idle(0); chk("t2_stall_done", {15'd0, s_stall}, 16'd0);
      chk("t2_instr", instr_o, 16'hA5A1);
      chk("t2_pc", imem_addr_o, 16'h0005);
      idle(0); idle(0);

      // 3: branch during a pending fetch at pc=7
      idle(2); chk("t3_addr", s_addr, 16'h0007);
      step(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      idle(0); chk("t3_drain_req", {15'd0, s_req}, 16'd0); chk("t3_drain_stall", {15'd0, s_stall}, 16'd1);
      chk("t3_instr_kept", instr_o, 16'hA5A3);
      idle(0); chk("t3_new_addr", s_addr, 16'h0020);
      chk("t3_instr_new", instr_o, 16'hA585);

      // 4: all redirects at once, interrupt wins
      step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h1234, 1'b0, 0);
      chk("t4_vector", imem_addr_o, 16'h0008);

      // 5: stall after ack at pc=9
      idle(0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      chk("t5_hold_req", {15'd0, s_req}, 16'd0); chk("t5_hold_stall", {15'd0, s_stall}, 16'd0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 0);
      chk("t5_instr", instr_o, 16'hA5AC); chk("t5_epc", epc_o, 16'h0009);
      idle(0);
      idle(0); chk("t5_release_addr", s_addr, 16'h000A);

      // 6: bus steal at pc=FFFF and wrap
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, 0);
`ifdef IF_PERF_CNT_EN
      cnt_before = int'(fetch_stall_cnt_o);
`endif
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 0);
      chk("t6_busy_req", {15'd0, s_req}, 16'd0); chk("t6_busy_stall", {15'd0, s_stall}, 16'd1);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 0);
      chk("t6_busy_req2", {15'd0, s_req}, 16'd0);
      idle(0); chk("t6_addr", s_addr, 16'hFFFF);
      chk("t6_epc", epc_o, 16'hFFFF); chk("t6_pcplus1", pcplus1_o, 16'h0000);
      chk("t6_wrap", imem_addr_o, 16'h0000);
`ifdef IF_PERF_CNT_EN
      chk("t6_cnt_delta", 16'(int'(fetch_stall_cnt_o) - cnt_before), 16'd2);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8, 16'($urandom),
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4, 16'($urandom),
              $urandom_range(0, 99) < 15, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
